nyq_filter: RTL and testbench



---
 rtl/nyq_filter.sv | 113 +++++++++++
 tb/tb_nyq_filter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/nyq_filter.sv
// -----------------------------------------------------------------------------
// nyq_filter
//
// Programmable 32-tap Nyquist (pulse-shaping) FIR filter. It sits in the
// transmit chain between the symbol mapper and the interpolator. The filter
// takes one sample on every clock edge; there is no valid strobe. The
// coefficient memory can be reloaded at runtime through a simple
// address/data/write-enable port while filtering continues.
//
// Optional feature macro: NYQ_ROUND_EN
//   defined   : 2**(FRAC_BITS-1) is added to the accumulator before the
//               shift (round half up), then the result is saturated.
//   undefined : the shift simply truncates toward minus infinity.
//
// Ports:
//   Clk_CI      in   1           clock, rising edge
//   Rst_RBI     in   1           synchronous active-low reset
//   WrEn_SI     in   1           coefficient write enable
//   Addr_DI     in   ADDR_WIDTH  coefficient index for the write
//   PAR_In_DI   in   MEM_WIDTH   coefficient write data (signed)
//   NYQ_In_DI   in   IN_WIDTH    input sample (signed)
//   NYQ_Out_DO  out  OUT_WIDTH   filtered sample, registered (signed)
//
// Timing: a sample presented before edge e enters D[0] at e. Its c[k]*x
// contribution appears on NYQ_Out_DO after edge e+1+k. A coefficient written
// at edge e is first used by the output produced at edge e+1.
// -----------------------------------------------------------------------------
module nyq_filter #(
    parameter int ADDR_WIDTH = 5,
    parameter int MEM_WIDTH  = 24,
    parameter int IN_WIDTH   = 24,
    parameter int OUT_WIDTH  = 24,
    parameter int FRAC_BITS  = 22
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RBI,
    input  logic                  WrEn_SI,
    input  logic [ADDR_WIDTH-1:0] Addr_DI,
    input  logic [MEM_WIDTH-1:0]  PAR_In_DI,
    input  logic [IN_WIDTH-1:0]   NYQ_In_DI,
    output logic [OUT_WIDTH-1:0]  NYQ_Out_DO
);

    localparam int NUM_TAPS = 2 ** ADDR_WIDTH;
    localparam int PROD_W   = MEM_WIDTH + IN_WIDTH;
    // The sum of NUM_TAPS full-scale products needs PROD_W+ADDR_WIDTH bits.
    // One extra bit leaves headroom for the rounding offset.
    localparam int ACC_W    = PROD_W + ADDR_WIDTH + 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        (ACC_W'(1) << (OUT_WIDTH - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [MEM_WIDTH-1:0] r_coef [NUM_TAPS];
    logic signed [IN_WIDTH-1:0]  r_dly  [NUM_TAPS];
    logic signed [OUT_WIDTH-1:0] r_out;

    logic signed [ACC_W-1:0]     w_acc;
    logic signed [ACC_W-1:0]     w_acc_adj;
    logic signed [ACC_W-1:0]     w_shift;
    logic signed [OUT_WIDTH-1:0] w_sat;

    // Full-precision multiply-accumulate over all taps. It uses the register
    // values from before the edge. Each operand is sign-extended to the
    // product width before the multiply, and each product is sign-extended
    // to the accumulator width before it is added.
    always_comb begin
        w_acc = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            w_acc = w_acc + ACC_W'(PROD_W'(r_coef[k]) * PROD_W'(r_dly[k]));
        end
    end

`ifdef NYQ_ROUND_EN
    assign w_acc_adj = w_acc + (ACC_W'(1) << (FRAC_BITS - 1));
`else
    assign w_acc_adj = w_acc;
`endif

    // An arithmetic shift on a signed value truncates toward minus infinity.
    assign w_shift = w_acc_adj >>> FRAC_BITS;

    always_comb begin
        w_sat = w_shift[OUT_WIDTH-1:0];
        if (w_shift > SAT_MAX) begin
            w_sat = SAT_MAX[OUT_WIDTH-1:0];
        end else if (w_shift < SAT_MIN) begin
            w_sat = SAT_MIN[OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                r_coef[k] <= '0;
                r_dly[k]  <= '0;
            end
            r_out <= '0;
        end else begin
            if (WrEn_SI) begin
                r_coef[Addr_DI] <= PAR_In_DI;
            end
            r_dly[0] <= NYQ_In_DI;
            for (int k = 1; k < NUM_TAPS; k++) begin
                r_dly[k] <= r_dly[k-1];
            end
            r_out <= w_sat;
        end
    end

    assign NYQ_Out_DO = r_out;

endmodule

// File: tb/tb_nyq_filter.sv
// -----------------------------------------------------------------------------
// tb_nyq_filter
//
// Self-checking bench for nyq_filter. For every driven cycle, a reference
// model (64-bit integers, written from the filter definition) computes the
// output expected after the coming edge and pushes it into exp_q. The value
// is popped and compared after the edge. Directed scenarios also compare key
// outputs against fixed constants. Define NYQ_ROUND_EN for both the bench and
// the RTL to build the rounding variant.
// -----------------------------------------------------------------------------
module tb_nyq_filter;

    localparam int W     = 24;
    localparam int TAPS  = 32;
    localparam int ONE   = 4194304;   // 1.0 in Q.22
    localparam int HALF  = 2097152;   // 0.5 in Q.22

    // ---------------- clock / reset ----------------
    logic          Clk_CI = 1'b0;
    logic          Rst_RBI;
    logic          WrEn_SI;
    logic [4:0]    Addr_DI;
    logic [W-1:0]  PAR_In_DI;
    logic [W-1:0]  NYQ_In_DI;
    logic [W-1:0]  NYQ_Out_DO;

    always #5 Clk_CI = ~Clk_CI;

    nyq_filter dut (
        .Clk_CI     (Clk_CI),
        .Rst_RBI    (Rst_RBI),
        .WrEn_SI    (WrEn_SI),
        .Addr_DI    (Addr_DI),
        .PAR_In_DI  (PAR_In_DI),
        .NYQ_In_DI  (NYQ_In_DI),
        .NYQ_Out_DO (NYQ_Out_DO)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           n_checks   = 0;
    int           n_failures = 0;
    int           last_out   = 0;

    longint m_c [TAPS];
    longint m_d [TAPS];

    task automatic check_val(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic longint sx24(input logic [W-1:0] v);
        return longint'($signed(v));
    endfunction

    // Reference output for the coming edge, computed from the model state
    // before the edge.
    function automatic logic [W-1:0] model_out();
        longint acc;
        longint y;
        acc = 0;
        for (int k = 0; k < TAPS; k++) acc += m_c[k] * m_d[k];
`ifdef NYQ_ROUND_EN
        acc += HALF;
`endif
        y = acc >>> 22;
        if (y > 8388607)  y = 8388607;
        if (y < -8388608) y = -8388608;
        return y[W-1:0];
    endfunction

    // ---------------- driver ----------------
    task automatic drive_cycle(input logic rst_n, input logic we, input int addr,
                               input longint cdata, input longint din);
        logic [W-1:0] exp_v;
        logic [W-1:0] cbits;
        logic [W-1:0] dbits;
        cbits     = cdata[W-1:0];
        dbits     = din[W-1:0];
        Rst_RBI   = rst_n;
        WrEn_SI   = we;
        Addr_DI   = addr[4:0];
        PAR_In_DI = cbits;
        NYQ_In_DI = dbits;
        if (!rst_n) begin
            exp_q.push_back('0);
            for (int k = 0; k < TAPS; k++) begin
                m_c[k] = 0;
                m_d[k] = 0;
            end
        end else begin
            exp_q.push_back(model_out());
            if (we) m_c[addr[4:0]] = sx24(cbits);
            for (int k = TAPS - 1; k > 0; k--) m_d[k] = m_d[k-1];
            m_d[0] = sx24(dbits);
        end
        @(posedge Clk_CI);
        #1;
        last_out = int'($signed(NYQ_Out_DO));
        if (exp_q.size() == 0) begin
            check_val("queue_empty", 1, 0);
        end else begin
            exp_v = exp_q.pop_front();
            check_val("out", last_out, int'($signed(exp_v)));
        end
    endtask

    task automatic do_reset();
        drive_cycle(1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic write_coef(input int addr, input longint val);
        drive_cycle(1'b1, 1'b1, addr, val, 0);
    endtask

    task automatic idle(input int n, input longint din);
        for (int i = 0; i < n; i++) drive_cycle(1'b1, 1'b0, 0, 0, din);
    endtask

    // ---------------- stimulus ----------------
    int obs [40];
    int coef_v;

    initial begin
        // Reset held for 3 cycles while a write and an input are requested.
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b1, i, 5555, 1000);
            check_val("rst_out", last_out, 0);
        end
        idle(5, 1000);
        check_val("post_rst_zero", last_out, 0);

        // Impulse response
        do_reset();
        write_coef(0, 100);
        write_coef(1, -200);
        write_coef(31, 7);
        idle(TAPS + 2, 0);
        drive_cycle(1'b1, 1'b0, 0, 0, ONE);
        obs[0] = last_out;
        for (int i = 1; i < 36; i++) begin
            drive_cycle(1'b1, 1'b0, 0, 0, 0);
            obs[i] = last_out;
        end
        check_val("imp_pre", obs[0], 0);
        check_val("imp_c0", obs[1], 100);
        check_val("imp_c1", obs[2], -200);
        check_val("imp_mid", obs[16], 0);
        check_val("imp_c31", obs[32], 7);
        check_val("imp_after", obs[33], 0);

        // DC step
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(k, 131072);
        for (int i = 0; i < 40; i++) begin
            drive_cycle(1'b1, 1'b0, 0, 0, ONE);
            obs[i] = last_out;
        end
        check_val("dc_first", obs[0], 0);
        check_val("dc_ramp1", obs[1], 131072);
        check_val("dc_ramp10", obs[10], 1310720);
        check_val("dc_settle", obs[32], 4194304);
        check_val("dc_hold", obs[39], 4194304);

        // Reset in the middle of operation clears everything.
        do_reset();
        check_val("mid_rst", last_out, 0);
        idle(3, ONE);
        check_val("mid_rst_coef_cleared", last_out, 0);

        // Saturation
        for (int k = 0; k < TAPS; k++) write_coef(k, 4194303);
        idle(40, 8388607);
        check_val("sat_pos", last_out, 8388607);
        idle(40, -8388608);
        check_val("sat_neg", last_out, -8388608);

        // Coefficient rewrite during filtering
        do_reset();
        write_coef(0, 1000);
        idle(3, ONE);
        check_val("wr_before", last_out, 1000);
        drive_cycle(1'b1, 1'b1, 0, 2000, ONE);
        check_val("wr_edge", last_out, 1000);
        idle(1, ONE);
        check_val("wr_after", last_out, 2000);

        // The last of back-to-back writes to one address wins.
        drive_cycle(1'b1, 1'b1, 0, 3000, ONE);
        drive_cycle(1'b1, 1'b1, 0, 4000, ONE);
        idle(1, ONE);
        check_val("wr_last_wins", last_out, 4000);

        // Truncation and rounding on a 0.5 impulse
        do_reset();
        write_coef(0, 3);
        drive_cycle(1'b1, 1'b0, 0, 0, HALF);
        idle(1, 0);
`ifdef NYQ_ROUND_EN
        check_val("round_pos", last_out, 2);
`else
        check_val("trunc_pos", last_out, 1);
`endif
        do_reset();
        write_coef(0, -3);
        drive_cycle(1'b1, 1'b0, 0, 0, HALF);
        idle(1, 0);
`ifdef NYQ_ROUND_EN
        // Round half up maps -1.5 to -1.
        check_val("round_neg", last_out, -1);
`else
        check_val("trunc_neg", last_out, -2);
`endif

        // Random coefficients, inputs and interleaved writes
        do_reset();
        for (int k = 0; k < TAPS; k++) begin
            coef_v = int'($urandom_range(0, 2 ** 19)) - 2 ** 18;
            write_coef(k, coef_v);
        end
        for (int i = 0; i < 300; i++) begin
            coef_v = int'($urandom_range(0, 2 ** 19)) - 2 ** 18;
            drive_cycle(1'b1, ($urandom_range(0, 7) == 0), int'($urandom_range(0, 31)),
                        coef_v, sx24(24'($urandom_range(0, 2 ** 24 - 1))));
        end

        // ---------------- report ----------------
        if (exp_q.size() != 0) check_val("queue_leftover", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
